// File: rtl/stopwatch_ctrl_if.sv
// Control and display bundle between the stopwatch core and its user side.
// The master side drives the buttons; the slave side (the core) drives the digits and strobes.
interface stopwatch_ctrl_if;
  logic       pause;
  logic       adj;
  logic       sel;
  logic [2:0] m10;
  logic [3:0] m1;
  logic [2:0] s10;
  logic [3:0] s1;
  logic       running;
  logic       tickDis;
  logic       blankMin;
  logic       blankSec;

  modport master (
    output pause, adj, sel,
    input  m10, m1, s10, s1, running, tickDis, blankMin, blankSec
  );

  modport slave (
    input  pause, adj, sel,
    output m10, m1, s10, s1, running, tickDis, blankMin, blankSec
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch with run/pause toggle, per-field adjust mode, display strobe and adjust blink.
// All timing derives from one free-running second counter plus two independent dividers.
module stopwatch_ctrl #(
  parameter int CLK_HZ   = 100000000,
  parameter int DIS_HZ   = 400,
  parameter int BLINK_HZ = 4
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave sw
);

  localparam int DIS_DIV   = CLK_HZ / DIS_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W     = (CLK_HZ > 1)    ? $clog2(CLK_HZ)    : 1;
  localparam int DIS_W     = (DIS_DIV > 1)   ? $clog2(DIS_DIV)   : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {RUN, PAUSED} state_t;

  state_t             r_state, w_stateNext;
  logic               r_pausePrev;
  logic [CNT_W-1:0]   r_cnt1;
  logic [DIS_W-1:0]   r_cntDis;
  logic [BLINK_W-1:0] r_cntBlink;
  logic               r_tickDis, r_blinkPhase, r_blankMin, r_blankSec;
  logic [2:0]         r_m10, r_s10, w_m10, w_s10, w_m10Inc, w_s10Inc;
  logic [3:0]         r_m1, r_s1, w_m1, w_s1, w_m1Inc, w_s1Inc;
  logic               w_tick1, w_tick2, w_disWrap, w_blinkWrap, w_pauseRise, w_secWrap;

  assign w_tick1     = (r_cnt1 == CNT_W'(CLK_HZ - 1));
  assign w_tick2     = w_tick1 || (r_cnt1 == CNT_W'(CLK_HZ / 2 - 1));
  assign w_disWrap   = (r_cntDis == DIS_W'(DIS_DIV - 1));
  assign w_blinkWrap = (r_cntBlink == BLINK_W'(BLINK_DIV - 1));
  assign w_pauseRise = sw.pause && !r_pausePrev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt1       <= '0;
      r_cntDis     <= '0;
      r_cntBlink   <= '0;
      r_tickDis    <= 1'b0;
      r_blinkPhase <= 1'b0;
    end else begin
      r_cnt1     <= w_tick1 ? '0 : r_cnt1 + 1'b1;
      r_cntDis   <= w_disWrap ? '0 : r_cntDis + 1'b1;
      r_cntBlink <= w_blinkWrap ? '0 : r_cntBlink + 1'b1;
      r_tickDis  <= w_disWrap;
      if (w_blinkWrap) r_blinkPhase <= ~r_blinkPhase;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_pausePrev <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_pausePrev <= sw.pause;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_pauseRise) w_stateNext = (r_state == RUN) ? PAUSED : RUN;
  end

  // Each field incremented on its own, 59 -> 00; w_secWrap tells the RUN path to carry.
  always_comb begin
    w_s1Inc   = (r_s1 == 4'd9) ? 4'd0 : r_s1 + 4'd1;
    w_s10Inc  = (r_s1 == 4'd9) ? ((r_s10 == 3'd5) ? 3'd0 : r_s10 + 3'd1) : r_s10;
    w_m1Inc   = (r_m1 == 4'd9) ? 4'd0 : r_m1 + 4'd1;
    w_m10Inc  = (r_m1 == 4'd9) ? ((r_m10 == 3'd5) ? 3'd0 : r_m10 + 3'd1) : r_m10;
    w_secWrap = (r_s10 == 3'd5) && (r_s1 == 4'd9);
  end

  always_comb begin
    w_m10 = r_m10;
    w_m1  = r_m1;
    w_s10 = r_s10;
    w_s1  = r_s1;
    if (sw.adj) begin
      if (w_tick2) begin
        if (sw.sel) begin
          w_s10 = w_s10Inc;
          w_s1  = w_s1Inc;
        end else begin
          w_m10 = w_m10Inc;
          w_m1  = w_m1Inc;
        end
      end
    end else if ((r_state == RUN) && w_tick1) begin
      w_s10 = w_s10Inc;
      w_s1  = w_s1Inc;
      if (w_secWrap) begin
        w_m10 = w_m10Inc;
        w_m1  = w_m1Inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m10      <= '0;
      r_m1       <= '0;
      r_s10      <= '0;
      r_s1       <= '0;
      r_blankMin <= 1'b0;
      r_blankSec <= 1'b0;
    end else begin
      r_m10      <= w_m10;
      r_m1       <= w_m1;
      r_s10      <= w_s10;
      r_s1       <= w_s1;
      r_blankMin <= sw.adj && !sw.sel && r_blinkPhase;
      r_blankSec <= sw.adj && sw.sel && r_blinkPhase;
    end
  end

  assign sw.m10      = r_m10;
  assign sw.m1       = r_m1;
  assign sw.s10      = r_s10;
  assign sw.s1       = r_s1;
  assign sw.running  = (r_state == RUN);
  assign sw.tickDis  = r_tickDis;
  assign sw.blankMin = r_blankMin;
  assign sw.blankSec = r_blankSec;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random buttons,
// every cycle compared against a time-arithmetic reference model.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ    = 8;
  localparam int DIS_HZ    = 4;
  localparam int BLINK_HZ  = 2;
  localparam int DIS_DIV   = CLK_HZ / DIS_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);

  logic clk;
  logic rst;
  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .DIS_HZ(DIS_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;
  int tickDisSeen = 0;

  // Reference model: time kept as whole minutes/seconds, ticks from edge counts since release.
  int   edges;
  int   mins, secs;
  bit   run, pPrev;
  logic expTickDis, expBlankMin, expBlankSec;

  always @(posedge clk or posedge rst) begin : refModel
    int n;
    bit t1, t2, ph;
    int total;
    if (rst) begin
      edges = 0; mins = 0; secs = 0; run = 1'b1; pPrev = 1'b0;
      expTickDis = 1'b0; expBlankMin = 1'b0; expBlankSec = 1'b0;
    end else begin
      n  = edges + 1;
      t1 = (n % CLK_HZ) == 0;
      t2 = (n % (CLK_HZ / 2)) == 0;
      ph = ((edges / BLINK_DIV) % 2) == 1;
      expBlankMin = sw.adj && !sw.sel && ph;
      expBlankSec = sw.adj && sw.sel && ph;
      if (sw.adj) begin
        if (t2) begin
          if (sw.sel) secs = (secs + 1) % 60;
          else        mins = (mins + 1) % 60;
        end
      end else if (run && t1) begin
        total = (mins * 60 + secs + 1) % 3600;
        mins  = total / 60;
        secs  = total % 60;
      end
      if (sw.pause && !pPrev) run = !run;
      pPrev      = sw.pause;
      expTickDis = (n % DIS_DIV) == 0;
      edges      = n;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    logic legal;
    legal = (sw.m10 <= 3'd5) && (sw.m1 <= 4'd9) && (sw.s10 <= 3'd5) && (sw.s1 <= 4'd9);
    checkOutput("m10", 32'(sw.m10), 32'(mins / 10));
    checkOutput("m1", 32'(sw.m1), 32'(mins % 10));
    checkOutput("s10", 32'(sw.s10), 32'(secs / 10));
    checkOutput("s1", 32'(sw.s1), 32'(secs % 10));
    checkOutput("running", 32'(sw.running), 32'(run));
    checkOutput("tickDis", 32'(sw.tickDis), 32'(expTickDis));
    checkOutput("blankMin", 32'(sw.blankMin), 32'(expBlankMin));
    checkOutput("blankSec", 32'(sw.blankSec), 32'(expBlankSec));
    checkOutput("bcdLegal", 32'(legal), 32'd1);
    if (sw.tickDis === 1'b1) tickDisSeen++;
  endtask

  task automatic applyStimulus(input bit p, input bit a, input bit s, input int cycles);
    sw.pause = p;
    sw.adj   = a;
    sw.sel   = s;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      compareAll();
    end
  endtask

  task automatic adjustTo(input int targetMin, input int targetSec);
    int guard;
    guard = 0;
    while (mins != targetMin && guard < 1000) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      guard++;
    end
    if (guard >= 1000) checkOutput("adjMinTimeout", 32'd1, 32'd0);
    guard = 0;
    while (secs != targetSec && guard < 1000) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1);
      guard++;
    end
    if (guard >= 1000) checkOutput("adjSecTimeout", 32'd1, 32'd0);
  endtask

  initial begin
    bit  seenZero, runBefore, rp, ra, rs;
    int  guard;
    clk = 1'b0;
    rst = 1'b0;
    sw.pause = 1'b0;
    sw.adj   = 1'b0;
    sw.sel   = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compareAll();
    checkOutput("resetRunning", 32'(sw.running), 32'd1);
    rst = 1'b0;

    // Plain counting from release.
    tickDisSeen = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 80);
    checkOutput("run80TickDis", 32'(tickDisSeen), 32'd40);
    checkOutput("run80S10", 32'(sw.s10), 32'd1);
    checkOutput("run80S1", 32'(sw.s1), 32'd0);
    checkOutput("run80M1", 32'(sw.m1), 32'd0);

    // Wrap through 59:59 to 00:00.
    adjustTo(59, 58);
    seenZero = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      if (sw.m10 == 3'd0 && sw.m1 == 4'd0 && sw.s10 == 3'd0 && sw.s1 == 4'd0) seenZero = 1'b1;
    end
    checkOutput("wrapSeenZero", 32'(seenZero), 32'd1);

    // Pause at 00:03, hold, resume, then a held pause toggles once.
    guard = 0;
    while (!(mins == 0 && secs == 3) && guard < 200) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      guard++;
    end
    if (guard >= 200) checkOutput("reach0003Timeout", 32'd1, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 40);
    checkOutput("pauseRunning", 32'(sw.running), 32'd0);
    checkOutput("pauseHoldS1", 32'(sw.s1), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16);
    checkOutput("resumeRunning", 32'(sw.running), 32'd1);
    runBefore = run;
    applyStimulus(1'b1, 1'b0, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("heldPauseOnce", 32'(sw.running), 32'(!runBefore));
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);

    // Seconds adjust across 59 -> 00, then minutes adjust and back to counting.
    adjustTo(mins, 58);
    applyStimulus(1'b0, 1'b1, 1'b1, 12);
    applyStimulus(1'b0, 1'b1, 1'b0, 16);
    applyStimulus(1'b0, 1'b0, 1'b0, 24);

    // Asynchronous reset mid-adjust at 12:34.
    adjustTo(12, 34);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    #2 rst = 1'b1;
    sw.adj = 1'b0;
    #1;
    checkOutput("asyncRstS1", 32'(sw.s1), 32'd0);
    checkOutput("asyncRstM1", 32'(sw.m1), 32'd0);
    checkOutput("asyncRstS10", 32'(sw.s10), 32'd0);
    checkOutput("asyncRstM10", 32'(sw.m10), 32'd0);
    checkOutput("asyncRstRunning", 32'(sw.running), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 7);
    checkOutput("postRstBefore8", 32'(sw.s1), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("postRstAt8", 32'(sw.s1), 32'd1);

    // Random button activity.
    ra = 1'b0;
    rs = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rp = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) ra = !ra;
      if ($urandom_range(0, 7) == 0) rs = !rs;
      applyStimulus(rp, ra, rs, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
